// File: rtl/ex_md_unit_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: md_op bit
// positions, FSM state encoding and a small operand helper.
package ex_md_unit_pkg;

  localparam int MD_MULT  = 0;
  localparam int MD_MULTU = 1;
  localparam int MD_DIV   = 2;
  localparam int MD_DIVU  = 3;
  localparam int MD_MTHI  = 4;
  localparam int MD_MTLO  = 5;
  localparam int MD_MFHI  = 6;
  localparam int MD_MFLO  = 7;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_MUL  = 2'd1,
    MD_DIV_ST = 2'd2
  } md_state_e;

  // Magnitude of a 32-bit value when treated as signed, raw value otherwise.
  function automatic logic [31:0] md_abs(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/ex_md_unit_divider.sv
// Iterative radix-2 restoring divider: one quotient bit per cycle, with
// start/done handshake, cancel, and final sign correction for signed ops.
module ex_md_unit_divider
  import ex_md_unit_pkg::*;
#(
  parameter int DIV_ITERS = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        is_signed,
  input  logic        cancel,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic        active;
  logic [4:0]  cnt;
  logic        neg_quo;
  logic        neg_rem;
  logic        div_zero;
  logic [31:0] rem_q;
  logic [31:0] quo_q;
  logic [31:0] dvsr_q;

  logic [32:0] shifted;
  logic        fits;
  logic [31:0] rem_next;
  logic [31:0] quo_next;

  // When the trial fits, the true difference is below 2^32, so a 32-bit
  // subtract is exact.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    shifted  = {rem_q, quo_q[31]};
    fits     = (shifted >= {1'b0, dvsr_q});
    rem_next = shifted[31:0];
    if (fits) rem_next = shifted[31:0] - dvsr_q;
    quo_next = {quo_q[30:0], fits};
  end

  assign done      = active && (cnt == 5'(DIV_ITERS - 1));
  // A zero divisor leaves the dividend in the remainder; only the quotient needs overriding.
  assign quotient  = div_zero ? 32'hFFFF_FFFF : (neg_quo ? (32'd0 - quo_next) : quo_next);
  assign remainder = neg_rem ? (32'd0 - rem_next) : rem_next;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
      active   <= 1'b0;
      cnt      <= 5'd0;
      neg_quo  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      rem_q    <= 32'd0;
      quo_q    <= 32'd0;
      dvsr_q   <= 32'd0;
    end else if (start) begin
      active   <= 1'b1;
      cnt      <= 5'd0;
      neg_quo  <= is_signed && (dividend[31] ^ divisor[31]);
      neg_rem  <= is_signed && dividend[31];
      div_zero <= (divisor == 32'd0);
      rem_q    <= 32'd0;
      quo_q    <= md_abs(dividend, is_signed);
      dvsr_q   <= md_abs(divisor, is_signed);
    end else if (active) begin
      if (cancel || done) begin
        active <= 1'b0;
      end else begin
        cnt   <= cnt + 5'd1;
        rem_q <= rem_next;
        quo_q <= quo_next;
      end
    end
  end

endmodule

// File: rtl/ex_md_unit.sv
// EX-stage multiply/divide unit: owns HI/LO, runs MULT/MULTU in one cycle
// and DIV/DIVU iteratively, and stalls EX while an operation is in flight.
module ex_md_unit
  import ex_md_unit_pkg::*;
#(
  parameter int DIV_ITERS = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        md_valid,
  input  logic [7:0]  md_op,
  input  logic [31:0] md_src1,
  input  logic [31:0] md_src2,
  input  logic        md_cancel,
  output logic        md_stall,
  output logic        md_busy,
  output logic [31:0] EX_MD_data
);

  md_state_e   state;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic        mul_signed;
  logic [63:0] product;

  logic        accept;
  logic        div_start;
  logic        div_done;
  logic [31:0] div_quo;
  logic [31:0] div_rem;

  assign md_busy  = (state != MD_IDLE);
  assign md_stall = md_valid && md_busy && !md_cancel;
  assign accept   = md_valid && !md_busy && !md_cancel;
  assign div_start = accept && (md_op[MD_DIV] || md_op[MD_DIVU]);

  // md_op is one-hot; a malformed code with both MF bits set reads LO.
  assign EX_MD_data = (md_op[MD_MFHI] && !md_op[MD_MFLO]) ? hi : lo;

  // Sign-extending to 64 bits makes the low half of an unsigned multiply
  // correct for both signed and unsigned operands.
  assign product = {{32{mul_signed & mul_a[31]}}, mul_a} *
                   {{32{mul_signed & mul_b[31]}}, mul_b};

  ex_md_unit_divider #(.DIV_ITERS(DIV_ITERS)) u_divider (
    .clk       (clk),
    .resetn    (resetn),
    .start     (div_start),
    .is_signed (md_op[MD_DIV]),
    .cancel    (md_cancel),
    .dividend  (md_src1),
    .divisor   (md_src2),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= MD_IDLE;
      hi         <= 32'd0;
      lo         <= 32'd0;
      mul_a      <= 32'd0;
      mul_b      <= 32'd0;
      mul_signed <= 1'b0;
    end else begin
      case (state)
        MD_IDLE: begin
          if (accept) begin
            if (md_op[MD_MTHI]) hi <= md_src1;
            if (md_op[MD_MTLO]) lo <= md_src1;
            if (md_op[MD_MULT] || md_op[MD_MULTU]) begin
              mul_a      <= md_src1;
              mul_b      <= md_src2;
              mul_signed <= md_op[MD_MULT];
              state      <= MD_MUL;
            end
            if (div_start) state <= MD_DIV_ST;
          end
        end
        MD_MUL: begin
          if (!md_cancel) {hi, lo} <= product;
          state <= MD_IDLE;
        end
        MD_DIV_ST: begin
          if (md_cancel) begin
            state <= MD_IDLE;
          end else if (div_done) begin
            hi    <= div_rem;
            lo    <= div_quo;
            state <= MD_IDLE;
          end
        end
        default: state <= MD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_md_unit.sv
// Scoreboard bench for ex_md_unit: directed ops, expected MF results queued
// at issue time and compared by a monitor when the MF is accepted.
module tb_ex_md_unit;
  import ex_md_unit_pkg::*;

  logic        clk;
  logic        resetn;
  logic        md_valid;
  logic [7:0]  md_op;
  logic [31:0] md_src1;
  logic [31:0] md_src2;
  logic        md_cancel;
  logic        md_stall;
  logic        md_busy;
  logic [31:0] EX_MD_data;

  ex_md_unit dut (
    .clk        (clk),
    .resetn     (resetn),
    .md_valid   (md_valid),
    .md_op      (md_op),
    .md_src1    (md_src1),
    .md_src2    (md_src2),
    .md_cancel  (md_cancel),
    .md_stall   (md_stall),
    .md_busy    (md_busy),
    .EX_MD_data (EX_MD_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, wanted %h", name, act, exp);
    end
  endtask

  task automatic expect_mf(input string name, input logic [31:0] val);
    exp_t e;
    e.name = name;
    e.val  = val;
    sb.push_back(e);
  endtask

  task automatic sync;
    @(posedge clk);
    #1;
  endtask

  // Present an op from just after a rising edge; hold it until accepted,
  // counting stall cycles. Returns just after the edge that ends the accept cycle.
  task automatic issue(input int op, input logic [31:0] a, input logic [31:0] b,
                       output int stalls);
    int budget;
    stalls   = 0;
    budget   = 0;
    md_valid = 1'b1;
    md_op    = '0;
    md_op[op] = 1'b1;
    md_src1  = a;
    md_src2  = b;
    forever begin
      @(negedge clk);
      if (!md_busy) break;
      if (md_stall) stalls++;
      budget++;
      if (budget > 200) begin
        n_vec++;
        n_miss++;
        $display("FAIL issue_timeout: op %0d still held after %0d cycles", op, budget);
        break;
      end
    end
    sync;
    md_valid = 1'b0;
    md_op    = '0;
  endtask

  task automatic busy_cycles(output int n);
    n = 0;
    forever begin
      @(negedge clk);
      if (!md_busy || n > 200) break;
      n++;
    end
    sync;
  endtask

  // Monitor: an accepted MFHI/MFLO is the point where the result is consumed.
  always @(negedge clk) begin
    if (resetn && md_valid && !md_busy && !md_cancel && (md_op[MD_MFHI] || md_op[MD_MFLO])) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_mf: got %h, wanted no read", EX_MD_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check(e.name, EX_MD_data, e.val);
      end
    end
  end

  initial begin
    int st;
    int nb;
    resetn    = 1'b0;
    md_valid  = 1'b0;
    md_op     = '0;
    md_src1   = '0;
    md_src2   = '0;
    md_cancel = 1'b0;
    #1;
    check("reset_busy", {31'd0, md_busy}, 32'd0);
    check("reset_stall", {31'd0, md_stall}, 32'd0);
    check("reset_data", EX_MD_data, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
    sync;

    // MULT / MULTU with the same operands
    issue(MD_MULT, 32'hFFFF_FFFF, 32'h0000_0002, st);
    busy_cycles(nb);
    check("mult_busy_cycles", nb, 32'd1);
    expect_mf("mult_hi", 32'hFFFF_FFFF); issue(MD_MFHI, 0, 0, st);
    expect_mf("mult_lo", 32'hFFFF_FFFE); issue(MD_MFLO, 0, 0, st);
    issue(MD_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, st);
    expect_mf("multu_hi", 32'h0000_0001); issue(MD_MFHI, 0, 0, st);
    expect_mf("multu_lo", 32'hFFFF_FFFE); issue(MD_MFLO, 0, 0, st);

    // DIVU 100/7 and DIV -7/2
    issue(MD_DIVU, 32'd100, 32'd7, st);
    busy_cycles(nb);
    check("divu_busy_cycles", nb, 32'd32);
    expect_mf("divu_lo", 32'd14); issue(MD_MFLO, 0, 0, st);
    expect_mf("divu_hi", 32'd2);  issue(MD_MFHI, 0, 0, st);
    issue(MD_DIV, 32'hFFFF_FFF9, 32'd2, st);
    expect_mf("div_neg_lo", 32'hFFFF_FFFD); issue(MD_MFLO, 0, 0, st);
    expect_mf("div_neg_hi", 32'hFFFF_FFFF); issue(MD_MFHI, 0, 0, st);

    // MFLO presented right after DIV: held 32 cycles, then reads 200/-10
    issue(MD_DIV, 32'd200, 32'hFFFF_FFF6, st);
    expect_mf("div_stall_lo", 32'hFFFF_FFEC); issue(MD_MFLO, 0, 0, st);
    check("div_stall_cycles", st, 32'd32);

    // Divide by zero and signed overflow
    issue(MD_DIV, 32'd5, 32'd0, st);
    expect_mf("div0_lo", 32'hFFFF_FFFF); issue(MD_MFLO, 0, 0, st);
    expect_mf("div0_hi", 32'd5);         issue(MD_MFHI, 0, 0, st);
    issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, st);
    expect_mf("ovf_lo", 32'h8000_0000); issue(MD_MFLO, 0, 0, st);
    expect_mf("ovf_hi", 32'd0);         issue(MD_MFHI, 0, 0, st);

    // MT then MF in consecutive cycles: no stall
    issue(MD_MTLO, 32'h0000_CAFE, 0, st);
    expect_mf("mt_mf_lo", 32'h0000_CAFE); issue(MD_MFLO, 0, 0, st);
    check("mt_mf_stalls", st, 32'd0);

    // Cancel a DIVU on its 10th divide cycle; LO keeps the preload
    issue(MD_MTLO, 32'h0000_1234, 0, st);
    issue(MD_DIVU, 32'd9, 32'd3, st);
    repeat (9) sync;
    md_cancel = 1'b1;
    sync;
    md_cancel = 1'b0;
    @(negedge clk);
    check("cancel_busy", {31'd0, md_busy}, 32'd0);
    sync;
    expect_mf("cancel_lo", 32'h0000_1234); issue(MD_MFLO, 0, 0, st);

    // MTHI with cancel in IDLE is dropped
    issue(MD_MTHI, 32'h0000_5555, 0, st);
    md_valid  = 1'b1;
    md_op     = '0;
    md_op[MD_MTHI] = 1'b1;
    md_src1   = 32'h0000_9999;
    md_cancel = 1'b1;
    sync;
    md_valid  = 1'b0;
    md_op     = '0;
    md_cancel = 1'b0;
    expect_mf("cancel_mthi_hi", 32'h0000_5555); issue(MD_MFHI, 0, 0, st);

    // Reset in the middle of a divide, with MFHI presented
    issue(MD_MTHI, 32'hABCD_0001, 0, st);
    issue(MD_DIVU, 32'd100, 32'd7, st);
    repeat (3) sync;
    md_valid = 1'b1;
    md_op    = '0;
    md_op[MD_MFHI] = 1'b1;
    #2;
    resetn = 1'b0;
    #1;
    check("midreset_busy", {31'd0, md_busy}, 32'd0);
    check("midreset_data_hi", EX_MD_data, 32'd0);
    md_op = '0;
    md_op[MD_MFLO] = 1'b1;
    #1;
    check("midreset_data_lo", EX_MD_data, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    md_valid = 1'b0;
    md_op    = '0;
    resetn   = 1'b1;
    sync;
    expect_mf("post_reset_hi", 32'd0); issue(MD_MFHI, 0, 0, st);

    repeat (2) sync;
    check("scoreboard_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, wanted finish");
    $fatal(1);
  end

endmodule

// File: doc/ex_md_unit.md
# ex_md_unit

Multiply/divide unit in the EX stage of the 5-stage MIPS core. It executes MULT/MULTU/DIV/DIVU/MTHI/MTLO and owns the HI/LO registers. It drives EX_MD_data, the EX-stage result for MFHI/MFLO, which feeds the ID-stage RAW forwarding path and the EX result mux. While an operation is in flight it raises a stall, so the pipeline never consumes a stale HI/LO.

## Interface
Parameters:
- DIV_ITERS, 32, number of radix-2 divide iterations. Fixed at 32 for a 32-bit datapath; not intended to be overridden.

Ports:
- clk  in  1  core clock, all state updates on rising edge
- resetn  in  1  asynchronous, active-low reset
- md_valid  in  1  EX holds a valid instruction carrying an md_op
- md_op  in  8  one-hot: MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI, MFLO
- md_src1  in  32  forwarded rs value (dividend / multiplicand / MT data)
- md_src2  in  32  forwarded rt value (divisor / multiplier)
- md_cancel  in  1  EX flush (exception/eret); kills any in-flight or presented op
- md_stall  out  1  combinational; EX must hold the instruction this cycle
- md_busy  out  1  registered; an operation is in flight
- EX_MD_data  out  32  HI if md_op[MFHI], else LO; combinational from the registers

## Operation
- State machine: IDLE, MUL, DIV. md_busy = (state != IDLE).
- md_stall = md_valid & md_busy & ~md_cancel. Applies to every md_op, including MFHI/MFLO.
- accept = md_valid & ~md_busy & ~md_cancel.
- IDLE + accept:
  - MTHI/MTLO: write HI/LO at this edge; stay IDLE.
  - MULT/MULTU: latch operands; go to MUL.
  - DIV/DIVU: latch |src1| and |src2| (signed) or the raw values (unsigned), plus the two sign bits; clear the counter; go to DIV.
  - MFHI/MFLO: no state change.
- MUL: compute the 64-bit product from the latched operands (signed or unsigned); write {HI,LO}; go to IDLE.
- DIV: restoring shift-subtract, one quotient bit per cycle; the 5-bit counter runs 0..31. When the counter reaches 31:
  - Sign-fix: negate the quotient if the operand signs differ; negate the remainder if the dividend is negative (signed op only).
  - Write LO = quotient, HI = remainder; go to IDLE.
- Divisor zero: LO = 0xFFFFFFFF, HI = src1 (raw); same count of cycles; no exception.
- 0x80000000 / -1 (signed): LO = 0x80000000, HI = 0.
- md_cancel in MUL or DIV: go to IDLE at the next edge; HI/LO unchanged.
- md_cancel together with md_valid in IDLE: nothing is accepted and no register is written.
- Reset: HI = LO = 0, state IDLE, counter 0, md_busy = 0, md_stall = 0. EX_MD_data therefore reads 0.
- Reset asserted mid-operation aborts it immediately; HI/LO = 0.

## Timing
- Accept in cycle T.
- MTHI/MTLO: new value visible on EX_MD_data in T+1.
- MULT/MULTU: md_busy high in T+1; HI/LO written at the end of T+1; a dependent MFHI completes in T+2.
- DIV/DIVU: md_busy high T+1..T+32; HI/LO written at the end of T+32; a dependent MFLO completes in T+33.
- An MF or MD op arriving while busy is held by md_stall and is accepted in the first cycle md_busy = 0.
- Back-to-back MT then MF in consecutive cycles needs no stall.

## Structure
- In the shared header mycpu.h:
  - `MD_MULT … `MD_MFLO bit indices for md_op.
  - State encodings MD_IDLE, MD_MUL, MD_DIV.
- One natural sub-module: md_divider, holding the iterative core, counter and sign-fix. It has a start/done interface with cancel.
- The multiplier stays inline as a registered `*`.

## Test plan
- Reset with resetn low for 3 cycles, mid-DIV.
  - Required: md_busy = 0 and EX_MD_data = 0 with MFHI or MFLO presented, immediately on resetn assertion.
- MULT 0xFFFFFFFF × 0x00000002, then MULTU with the same operands.
  - MULT: HI = 0xFFFFFFFF, LO = 0xFFFFFFFE, md_busy for exactly 1 cycle.
  - MULTU: HI = 0x00000001, LO = 0xFFFFFFFE.
- DIVU 100/7, then DIV −7/2.
  - DIVU: md_busy for 32 cycles, then LO = 14, HI = 2.
  - DIV: LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
- MFLO presented the cycle after DIV is accepted.
  - Required: md_stall high for 32 cycles, then EX_MD_data = the new quotient.
- DIV 5/0 and DIV 0x80000000/0xFFFFFFFF.
  - 5/0: LO = 0xFFFFFFFF, HI = 5.
  - 0x80000000/0xFFFFFFFF: LO = 0x80000000, HI = 0.
- Preload LO = 0x1234 via MTLO, start DIVU 9/3, then assert md_cancel on divide cycle 10.
  - Required: md_busy low in the next cycle, LO still 0x1234.
  - md_cancel together with md_valid (MTHI) in IDLE leaves HI unchanged.
